// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file and interrupt controller:
// CSR addresses, CSR operation codes, interrupt cause codes and mstatus bits.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MIE       = 12'h304;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MIP       = 12'h344;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_e;

   // Cause codes double as mip/mie bit positions
   localparam int unsigned IRQ_SOFT   = 3;
   localparam int unsigned IRQ_TIMER  = 7;
   localparam int unsigned IRQ_EXT    = 11;
   localparam int unsigned IRQ_LOCAL0 = 16;

   localparam int unsigned MSTATUS_MIE  = 3;
   localparam int unsigned MSTATUS_MPIE = 7;

endpackage

// File: rtl/csr_irq_arbiter.sv
// Fixed-priority interrupt encoder: ext > soft > timer > local[0] > local[1] > ...
module csr_irq_arbiter
   import csr_pkg::*;
#(
   parameter int unsigned NUM_LOCAL = 4
) (
   input  logic [31:0] pending,
   output logic        any,
   output logic [4:0]  cause
);

   // Lowest-priority sources are assigned first so higher ones overwrite them
   always_comb begin
      any   = |pending;
      cause = '0;
      for (int i = int'(NUM_LOCAL) - 1; i >= 0; i--) begin
         if (pending[int'(IRQ_LOCAL0) + i]) cause = 5'(int'(IRQ_LOCAL0) + i);
      end
      if (pending[IRQ_TIMER]) cause = 5'(IRQ_TIMER);
      if (pending[IRQ_SOFT])  cause = 5'(IRQ_SOFT);
      if (pending[IRQ_EXT])   cause = 5'(IRQ_EXT);
   end

endmodule

// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file with interrupt trap entry, mret handling and
// 64-bit cycle/instret counters; returns CSR read data and PC redirects.
module csr_trap_unit
   import csr_pkg::*;
#(
   parameter int unsigned XLEN      = 32,
   parameter int unsigned NUM_LOCAL = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [11:0]          csr_addr,
   input  logic [1:0]           csr_op,
   input  logic                 csr_rd_en,
   input  logic [XLEN-1:0]      csr_wdata,
   output logic [XLEN-1:0]      csr_rdata,
   output logic                 csr_illegal,
   input  logic [XLEN-1:0]      pc,
   input  logic                 pc_valid,
   input  logic                 is_mret,
   input  logic                 instr_retire,
   input  logic                 irq_timer,
   input  logic                 irq_soft,
   input  logic                 irq_ext,
   input  logic [NUM_LOCAL-1:0] irq_local,
   output logic                 redirect,
   output logic [XLEN-1:0]      redirect_pc
);

   localparam int unsigned CNT_W = 2 * XLEN;
   localparam logic [XLEN-1:0] LOCAL_MASK =
      XLEN'(((64'(1) << NUM_LOCAL) - 64'(1)) << IRQ_LOCAL0);
   localparam logic [XLEN-1:0] MIE_MASK = LOCAL_MASK | (XLEN'(1) << IRQ_SOFT)
                                        | (XLEN'(1) << IRQ_TIMER) | (XLEN'(1) << IRQ_EXT);

   logic             mstatus_mie_q, mstatus_mie_d;
   logic             mstatus_mpie_q, mstatus_mpie_d;
   logic [XLEN-1:0]  mie_q, mie_d;
   logic [XLEN-1:0]  mtvec_q, mtvec_d;
   logic [XLEN-1:0]  mscratch_q, mscratch_d;
   logic [XLEN-1:0]  mepc_q, mepc_d;
   logic [XLEN-1:0]  mcause_q, mcause_d;
   logic [XLEN-1:0]  mip_q, mip_d;
   logic [CNT_W-1:0] mcycle_q, mcycle_d;
   logic [CNT_W-1:0] minstret_q, minstret_d;

   csr_op_e          op;
   logic [XLEN-1:0]  rd_val;
   logic [XLEN-1:0]  wr_val;
   logic             addr_known;
   logic             wr_en;
   logic             irq_any;
   logic [4:0]       irq_cause;
   logic             trap_fire;
   logic             mret_fire;
   logic [XLEN-1:0]  trap_base;

   assign op = csr_op_e'(csr_op);

   csr_irq_arbiter #(
      .NUM_LOCAL (NUM_LOCAL)
   ) u_arb (
      .pending (mip_q & mie_q),
      .any     (irq_any),
      .cause   (irq_cause)
   );

   assign trap_fire = irq_any && mstatus_mie_q && pc_valid && !is_mret;
   assign mret_fire = pc_valid && is_mret;
   assign trap_base = mtvec_q & ~XLEN'(3);

   // Pre-update read mux and access legality
   always_comb begin
      rd_val     = '0;
      addr_known = 1'b1;
      case (csr_addr)
         CSR_MSTATUS: begin
            rd_val[MSTATUS_MIE]  = mstatus_mie_q;
            rd_val[MSTATUS_MPIE] = mstatus_mpie_q;
         end
         CSR_MIE:       rd_val = mie_q;
         CSR_MTVEC:     rd_val = mtvec_q;
         CSR_MSCRATCH:  rd_val = mscratch_q;
         CSR_MEPC:      rd_val = mepc_q;
         CSR_MCAUSE:    rd_val = mcause_q;
         CSR_MIP:       rd_val = mip_q;
         CSR_MCYCLE:    rd_val = mcycle_q[XLEN-1:0];
         CSR_MCYCLEH:   rd_val = mcycle_q[CNT_W-1:XLEN];
         CSR_MINSTRET:  rd_val = minstret_q[XLEN-1:0];
         CSR_MINSTRETH: rd_val = minstret_q[CNT_W-1:XLEN];
         default:       addr_known = 1'b0;
      endcase

      csr_illegal = (csr_rd_en || op != CSR_OP_NONE)
                 && (!addr_known || (csr_addr == CSR_MIP && op != CSR_OP_NONE));
      csr_rdata   = (csr_rd_en && !csr_illegal) ? rd_val : '0;

      case (op)
         CSR_OP_WRITE: wr_val = csr_wdata;
         CSR_OP_SET:   wr_val = rd_val | csr_wdata;
         CSR_OP_CLEAR: wr_val = rd_val & ~csr_wdata;
         default:      wr_val = rd_val;
      endcase
      // A trapping instruction is flushed, so its CSR side effect is dropped
      wr_en = (op != CSR_OP_NONE) && !csr_illegal && !trap_fire;

      redirect    = trap_fire || mret_fire;
      redirect_pc = '0;
      if (trap_fire) begin
         redirect_pc = trap_base + (mtvec_q[0] ? XLEN'({irq_cause, 2'b00}) : '0);
      end else if (mret_fire) begin
         redirect_pc = mepc_q;
      end
   end

   // Next-state: counters, CSR writes, then trap/mret overrides
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_d          = mie_q;
      mtvec_d        = mtvec_q;
      mscratch_d     = mscratch_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      mcycle_d       = mcycle_q + CNT_W'(1);
      minstret_d     = minstret_q + CNT_W'(instr_retire);

      mip_d                             = '0;
      mip_d[IRQ_SOFT]                   = irq_soft;
      mip_d[IRQ_TIMER]                  = irq_timer;
      mip_d[IRQ_EXT]                    = irq_ext;
      mip_d[IRQ_LOCAL0 +: NUM_LOCAL]    = irq_local;

      if (wr_en) begin
         case (csr_addr)
            CSR_MSTATUS: begin
               mstatus_mie_d  = wr_val[MSTATUS_MIE];
               mstatus_mpie_d = wr_val[MSTATUS_MPIE];
            end
            CSR_MIE:       mie_d      = wr_val & MIE_MASK;
            CSR_MTVEC:     mtvec_d    = wr_val;
            CSR_MSCRATCH:  mscratch_d = wr_val;
            CSR_MEPC:      mepc_d     = wr_val & ~XLEN'(3);
            CSR_MCAUSE:    mcause_d   = wr_val;
            CSR_MCYCLE:    mcycle_d[XLEN-1:0]       = wr_val;
            CSR_MCYCLEH:   mcycle_d[CNT_W-1:XLEN]   = wr_val;
            CSR_MINSTRET:  minstret_d[XLEN-1:0]     = wr_val;
            CSR_MINSTRETH: minstret_d[CNT_W-1:XLEN] = wr_val;
            default: ;
         endcase
      end

      if (trap_fire) begin
         mepc_d         = pc & ~XLEN'(3);
         mcause_d       = (XLEN'(1) << (XLEN - 1)) | XLEN'(irq_cause);
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_fire) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_q          <= '0;
         mtvec_q        <= '0;
         mscratch_q     <= '0;
         mepc_q         <= '0;
         mcause_q       <= '0;
         mip_q          <= '0;
         mcycle_q       <= '0;
         minstret_q     <= '0;
      end else begin
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_q          <= mie_d;
         mtvec_q        <= mtvec_d;
         mscratch_q     <= mscratch_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         mip_q          <= mip_d;
         mcycle_q       <= mcycle_d;
         minstret_q     <= minstret_d;
      end
   end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboarded bench for csr_trap_unit: a behavioural CSR/trap model predicts
// each cycle's combinational outputs; a monitor compares them at negedge.
module tb_csr_trap_unit;

   localparam int unsigned NL = 4;

   typedef struct {
      logic          rst;
      logic [11:0]   addr;
      logic [1:0]    op;
      logic          rd_en;
      logic [31:0]   wdata;
      logic [31:0]   pc;
      logic          pc_valid;
      logic          is_mret;
      logic          retire;
      logic          irq_t;
      logic          irq_s;
      logic          irq_e;
      logic [NL-1:0] irq_l;
   } stim_t;

   typedef struct {
      logic [31:0] rdata;
      logic        illegal;
      logic        redirect;
      logic [31:0] rpc;
   } exp_t;

   logic          clk;
   logic          rst;
   logic [11:0]   csr_addr;
   logic [1:0]    csr_op;
   logic          csr_rd_en;
   logic [31:0]   csr_wdata;
   logic [31:0]   csr_rdata;
   logic          csr_illegal;
   logic [31:0]   pc;
   logic          pc_valid;
   logic          is_mret;
   logic          instr_retire;
   logic          irq_timer;
   logic          irq_soft;
   logic          irq_ext;
   logic [NL-1:0] irq_local;
   logic          redirect;
   logic [31:0]   redirect_pc;

   int tests_run    = 0;
   int tests_failed = 0;

   exp_t exp_q[$];
   int   prio_q[$];

   // Reference model state (architectural view)
   logic        m_mieb, m_mpie;
   logic [31:0] m_mie, m_mtvec, m_scr, m_mepc, m_mcause, m_mip;
   logic [63:0] m_cyc, m_ret;

   // Current level of the interrupt lines, held across helper calls
   logic          cur_t, cur_s, cur_e;
   logic [NL-1:0] cur_l;

   csr_trap_unit #(.XLEN(32), .NUM_LOCAL(NL)) dut (
      .clk          (clk),
      .rst          (rst),
      .csr_addr     (csr_addr),
      .csr_op       (csr_op),
      .csr_rd_en    (csr_rd_en),
      .csr_wdata    (csr_wdata),
      .csr_rdata    (csr_rdata),
      .csr_illegal  (csr_illegal),
      .pc           (pc),
      .pc_valid     (pc_valid),
      .is_mret      (is_mret),
      .instr_retire (instr_retire),
      .irq_timer    (irq_timer),
      .irq_soft     (irq_soft),
      .irq_ext      (irq_ext),
      .irq_local    (irq_local),
      .redirect     (redirect),
      .redirect_pc  (redirect_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, got, want, $time);
      end
   endtask

   // Monitor: every cycle with a queued prediction is checked mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("csr_rdata",   csr_rdata,          e.rdata);
            cmp("csr_illegal", 32'(csr_illegal),   32'(e.illegal));
            cmp("redirect",    32'(redirect),      32'(e.redirect));
            cmp("redirect_pc", redirect_pc,        e.rpc);
         end
      end
   end

   function automatic stim_t idle();
      stim_t s;
      s.rst = 1'b0; s.addr = 12'h000; s.op = 2'd0; s.rd_en = 1'b0; s.wdata = '0;
      s.pc = '0; s.pc_valid = 1'b0; s.is_mret = 1'b0; s.retire = 1'b0;
      s.irq_t = cur_t; s.irq_s = cur_s; s.irq_e = cur_e; s.irq_l = cur_l;
      return s;
   endfunction

   // Drive one cycle, predict its outputs, then advance the model over the edge
   task automatic run_cycle(input stim_t s);
      logic [31:0] old, w, pend;
      logic        known, illegal, take, mret, wr;
      int          cause;
      exp_t        e;
      logic        n_mieb, n_mpie;
      logic [31:0] n_mie, n_mtvec, n_scr, n_mepc, n_mcause, n_mip;
      logic [63:0] n_cyc, n_ret;

      rst = s.rst; csr_addr = s.addr; csr_op = s.op; csr_rd_en = s.rd_en;
      csr_wdata = s.wdata; pc = s.pc; pc_valid = s.pc_valid; is_mret = s.is_mret;
      instr_retire = s.retire; irq_timer = s.irq_t; irq_soft = s.irq_s;
      irq_ext = s.irq_e; irq_local = s.irq_l;

      known = 1'b1;
      old   = '0;
      case (s.addr)
         12'h300: old = (32'(m_mieb) << 3) | (32'(m_mpie) << 7);
         12'h304: old = m_mie;
         12'h305: old = m_mtvec;
         12'h340: old = m_scr;
         12'h341: old = m_mepc;
         12'h342: old = m_mcause;
         12'h344: old = m_mip;
         12'hB00: old = m_cyc[31:0];
         12'hB80: old = m_cyc[63:32];
         12'hB02: old = m_ret[31:0];
         12'hB82: old = m_ret[63:32];
         default: known = 1'b0;
      endcase
      illegal = (s.rd_en || s.op != 2'd0) && (!known || (s.addr == 12'h344 && s.op != 2'd0));

      pend  = m_mip & m_mie;
      cause = -1;
      foreach (prio_q[k]) if (cause < 0 && pend[prio_q[k]]) cause = prio_q[k];
      take = (cause >= 0) && m_mieb && s.pc_valid && !s.is_mret;
      mret = s.pc_valid && s.is_mret;

      e.rdata    = (s.rd_en && !illegal) ? old : 32'h0;
      e.illegal  = illegal;
      e.redirect = take || mret;
      if (take)      e.rpc = {m_mtvec[31:2], 2'b00} + (m_mtvec[0] ? 32'(4 * cause) : 32'h0);
      else if (mret) e.rpc = m_mepc;
      else           e.rpc = 32'h0;
      if (!s.rst) exp_q.push_back(e);

      case (s.op)
         2'd1:    w = s.wdata;
         2'd2:    w = old | s.wdata;
         2'd3:    w = old & ~s.wdata;
         default: w = old;
      endcase

      n_mieb = m_mieb; n_mpie = m_mpie; n_mie = m_mie; n_mtvec = m_mtvec;
      n_scr = m_scr; n_mepc = m_mepc; n_mcause = m_mcause;
      n_cyc = m_cyc + 64'd1;
      n_ret = m_ret + (s.retire ? 64'd1 : 64'd0);
      wr = (s.op != 2'd0) && !illegal && !take;
      if (wr) begin
         case (s.addr)
            12'h300: begin n_mieb = w[3]; n_mpie = w[7]; end
            12'h304: n_mie    = w & (32'h0000_0888 | (((32'h1 << NL) - 32'h1) << 16));
            12'h305: n_mtvec  = w;
            12'h340: n_scr    = w;
            12'h341: n_mepc   = {w[31:2], 2'b00};
            12'h342: n_mcause = w;
            12'hB00: n_cyc[31:0]  = w;
            12'hB80: n_cyc[63:32] = w;
            12'hB02: n_ret[31:0]  = w;
            12'hB82: n_ret[63:32] = w;
            default: ;
         endcase
      end
      if (take) begin
         n_mepc   = {s.pc[31:2], 2'b00};
         n_mcause = 32'h8000_0000 | 32'(cause);
         n_mpie   = m_mieb;
         n_mieb   = 1'b0;
      end else if (mret) begin
         n_mieb = m_mpie;
         n_mpie = 1'b1;
      end
      n_mip = '0;
      n_mip[3]  = s.irq_s;
      n_mip[7]  = s.irq_t;
      n_mip[11] = s.irq_e;
      n_mip[16 +: NL] = s.irq_l;

      if (s.rst) begin
         n_mieb = 0; n_mpie = 0; n_mie = 0; n_mtvec = 0; n_scr = 0; n_mepc = 0;
         n_mcause = 0; n_mip = 0; n_cyc = 0; n_ret = 0;
      end

      @(posedge clk);
      m_mieb = n_mieb; m_mpie = n_mpie; m_mie = n_mie; m_mtvec = n_mtvec;
      m_scr = n_scr; m_mepc = n_mepc; m_mcause = n_mcause; m_mip = n_mip;
      m_cyc = n_cyc; m_ret = n_ret;
      #1;
   endtask

   task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic rd, input logic [31:0] wd);
      stim_t s;
      s = idle(); s.addr = a; s.op = op; s.rd_en = rd; s.wdata = wd;
      run_cycle(s);
   endtask

   task automatic rd(input logic [11:0] a);
      csr(a, 2'd0, 1'b1, 32'h0);
   endtask

   task automatic instr(input logic [31:0] p, input logic mret_i);
      stim_t s;
      s = idle(); s.pc = p; s.pc_valid = 1'b1; s.is_mret = mret_i; s.retire = 1'b1;
      run_cycle(s);
   endtask

   task automatic do_reset(input int cycles);
      stim_t s;
      s = idle(); s.rst = 1'b1;
      repeat (cycles) run_cycle(s);
   endtask

   logic [11:0] addr_list [12];

   initial begin
      stim_t s;
      addr_list = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                    12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h7C0};
      prio_q = {11, 3, 7};
      for (int i = 0; i < int'(NL); i++) prio_q.push_back(16 + i);
      cur_t = 0; cur_s = 0; cur_e = 0; cur_l = '0;
      m_mieb = 0; m_mpie = 0; m_mie = 0; m_mtvec = 0; m_scr = 0; m_mepc = 0;
      m_mcause = 0; m_mip = 0; m_cyc = 0; m_ret = 0;

      s = idle(); s.rst = 1'b1;
      rst = 1; csr_addr = 0; csr_op = 0; csr_rd_en = 0; csr_wdata = 0; pc = 0;
      pc_valid = 0; is_mret = 0; instr_retire = 0; irq_timer = 0; irq_soft = 0;
      irq_ext = 0; irq_local = '0;
      @(posedge clk); #1;
      do_reset(2);

      // Reset values of every CSR, then an unknown address
      foreach (addr_list[i]) rd(addr_list[i]);

      // Vectored external interrupt trap
      csr(12'h305, 2'd1, 1'b0, 32'h0000_1001);
      csr(12'h304, 2'd1, 1'b0, 32'h0000_0800);
      csr(12'h300, 2'd1, 1'b0, 32'h0000_0008);
      cur_e = 1; run_cycle(idle());
      cur_e = 0; instr(32'h200, 1'b0);
      rd(12'h341); rd(12'h342); rd(12'h300);

      // Priority among simultaneous sources, then timer after mret
      csr(12'h304, 2'd1, 1'b0, 32'h0001_0888);
      cur_t = 1; cur_e = 1; cur_l = 4'b0001; run_cycle(idle());
      csr(12'h300, 2'd1, 1'b1, 32'h0000_0008);
      instr(32'h300, 1'b0);
      rd(12'h342);
      cur_e = 0; instr(32'h300, 1'b1);
      instr(32'h304, 1'b0);
      rd(12'h342); rd(12'h300);
      cur_t = 0; cur_l = '0; run_cycle(idle());

      // mret beats a simultaneous interrupt; mret beats mstatus write
      csr(12'h341, 2'd1, 1'b0, 32'h0000_0200);
      cur_e = 1; run_cycle(idle());
      instr(32'h400, 1'b1);
      rd(12'h300);
      instr(32'h404, 1'b0);
      cur_e = 0; run_cycle(idle());
      s = idle(); s.pc = 32'h500; s.pc_valid = 1; s.is_mret = 1;
      s.addr = 12'h300; s.op = 2'd1; s.wdata = 32'h0; run_cycle(s);
      rd(12'h300);

      // SET/CLEAR on mie, writes to read-only mip
      csr(12'h304, 2'd1, 1'b0, 32'h0);
      csr(12'h304, 2'd2, 1'b1, 32'h80); rd(12'h304);
      csr(12'h304, 2'd3, 1'b1, 32'h80); rd(12'h304);
      cur_s = 1; run_cycle(idle());
      csr(12'h344, 2'd1, 1'b1, 32'hFFFF_FFFF); rd(12'h344);
      cur_s = 0; run_cycle(idle());

      // Counter carry and write-wins-over-increment
      csr(12'hB00, 2'd1, 1'b0, 32'hFFFF_FFFE);
      repeat (3) run_cycle(idle());
      rd(12'hB80); rd(12'hB00);
      s = idle(); s.retire = 1; s.addr = 12'hB02; s.op = 2'd1; s.wdata = 32'h1234; run_cycle(s);
      rd(12'hB02); rd(12'hB82);

      // Reset while interrupts are asserted and pending
      csr(12'h304, 2'd1, 1'b0, 32'hFFFF_FFFF);
      cur_t = 1; cur_l = 4'b1010; run_cycle(idle());
      do_reset(1);
      cur_t = 0; cur_l = '0;
      rd(12'h344); rd(12'h304); rd(12'hB00);

      // Randomised traffic
      for (int n = 0; n < 2000; n++) begin
         s = idle();
         s.rst      = ($urandom_range(0, 499) == 0);
         s.addr     = ($urandom_range(0, 19) == 0) ? 12'($urandom) : addr_list[$urandom_range(0, 11)];
         s.op       = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'd0;
         s.rd_en    = 1'($urandom);
         s.wdata    = ($urandom_range(0, 1) == 0) ? 32'($urandom) : 32'(1 << $urandom_range(0, 19));
         s.pc       = 32'($urandom);
         s.pc_valid = ($urandom_range(0, 9) < 7);
         s.is_mret  = ($urandom_range(0, 9) == 0);
         s.retire   = 1'($urandom);
         s.irq_t    = ($urandom_range(0, 4) == 0);
         s.irq_s    = ($urandom_range(0, 4) == 0);
         s.irq_e    = ($urandom_range(0, 4) == 0);
         s.irq_l    = NL'($urandom) & NL'($urandom);
         run_cycle(s);
      end

      cur_t = 0; cur_s = 0; cur_e = 0; cur_l = '0;
      repeat (2) run_cycle(idle());
      @(negedge clk); #1;
      cmp("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/csr_trap_unit.md
# csr_trap_unit

Machine-mode CSR file and interrupt controller for the three-stage core, generalised to a configurable number of local interrupt lines. Adds a fixed-priority arbiter, mstatus MIE/MPIE stacking, RISC-V set/clear CSR operations, mscratch, and 64-bit mcycle/minstret counters. Sits beside the execute stage: it takes CSR accesses and the current PC, and returns read data plus a PC redirect on trap entry or mret.

## Interface
- XLEN, 32, data width (only 32 is supported)
- NUM_LOCAL, 4, local interrupt lines (1..16), mapped to mip/mie bits 16..16+NUM_LOCAL-1
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- csr_addr  in  12  CSR address
- csr_op  in  2  csr_op_e: NONE=0, WRITE=1, SET=2, CLEAR=3
- csr_rd_en  in  1  read access this cycle
- csr_wdata  in  XLEN  write operand or mask
- csr_rdata  out  XLEN  current value of the addressed CSR (pre-update); 0 when csr_rd_en=0
- csr_illegal  out  1  unknown address, or a write/set/clear to read-only mip
- pc  in  XLEN  PC of the instruction in execute
- pc_valid  in  1  execute holds a real instruction (not a bubble)
- is_mret  in  1  mret in execute
- instr_retire  in  1  one instruction retires this cycle
- irq_timer, irq_soft, irq_ext  in  1 each  level-sensitive standard interrupts
- irq_local  in  NUM_LOCAL  level-sensitive local interrupts
- redirect  out  1  flush and fetch from redirect_pc
- redirect_pc  out  XLEN  trap vector or mepc

## Operation
- CSRs: mstatus 0x300 (MIE bit 3, MPIE bit 7; all other bits read 0), mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341 (bits [1:0] forced 0), mcause 0x342, mip 0x344 (read-only), mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82.
- Write data: WRITE gives wdata; SET gives old|wdata; CLEAR gives old&~wdata. mie is writable only at implemented bits (3, 7, 11, 16..16+NUM_LOCAL-1).
- mip: registered copy of the irq inputs, updated every cycle (bit 3 soft, 7 timer, 11 ext, 16+i local[i]).
- Pending = mip & mie. Take a trap when pending != 0, mstatus.MIE=1, pc_valid=1 and is_mret=0.
- Priority: ext (11) > soft (3) > timer (7) > local[0] > local[1] > ...
- Trap entry: mepc<=pc; mcause<={1'b1, cause}; MPIE<=MIE; MIE<=0; redirect=1.
- redirect_pc: mtvec[0]=0 (direct) gives {mtvec[31:2],00}; mtvec[0]=1 (vectored) gives {mtvec[31:2],00}+4*cause.
- mret (when pc_valid=1): MIE<=MPIE; MPIE<=1; redirect=1; redirect_pc=mepc.
- Counters: mcycle increments every cycle. minstret increments when instr_retire=1. A write to either half replaces that half, and the write wins over the increment in that cycle. A carry from the low half propagates into the high half.
- csr_illegal=1 suppresses the access: no state change, rdata=0.

## Timing
- Reset: all CSRs 0, mip 0, counters 0, redirect 0, redirect_pc 0, csr_rdata 0, csr_illegal 0.
- csr_rdata, csr_illegal, redirect and redirect_pc are combinational. All state updates on the next clk edge.
- Interrupt latency: irq asserted in cycle N → mip set in N+1 → redirect in N+1 at the earliest.
- A CSR access in the same cycle as a trap entry is suppressed (that instruction is flushed and re-executes after mret).
- mret and an interrupt in the same cycle: mret wins. The interrupt is re-evaluated the following cycle using the restored MIE.
- CSR write to mstatus in the same cycle as mret: mret wins.
- pc_valid=0 blocks both trap entry and mret.
- Writing mstatus.MIE=1 while an interrupt is pending: the trap is taken one cycle later, on the first cycle with pc_valid=1.
- Reset asserted mid-operation clears everything in the same edge, including pending mip.

## Structure
- csr_pkg holds: CSR address localparams, csr_op_e, cause codes (3, 7, 11, 16+i), and MIE/MPIE bit indices.
- Sub-module csr_irq_arbiter: combinational fixed-priority encoder from pending to (any, cause[4:0]), parametrised by NUM_LOCAL.

## Test plan
- Reset, then read every CSR → all 0. Read 0x7C0 → csr_illegal=1, rdata=0.
- Write mtvec=0x1001, mie=0x800, mstatus=0x8, then pulse irq_ext with pc=0x200 → redirect=1, redirect_pc=0x102C, mepc=0x200, mcause=0x8000000B, mstatus=0x80.
- Set mie=0x10888 and raise irq_timer, irq_ext and irq_local[0] together → cause 11 taken. After mret with irq_ext dropped, the timer trap (cause 7) is taken next.
- mret with mepc=0x200 and MPIE=1 → redirect_pc=0x200, mstatus MIE=1, MPIE=1. A simultaneous irq_ext does not redirect in that cycle.
- CSR SET on mie (0x80) then CLEAR (0x80) → reads 0x80, then 0. A write to mip → illegal, and mip is unchanged.
- Write mcycle=0xFFFFFFFE, hold 3 cycles → mcycleh=1, mcycle=1. Write minstret in a retire cycle → written value kept, no increment.
